// File: rtl/cc_cond_unit_pkg.sv
// Shared constants for the Y86-64 execute-stage condition-code unit:
// operand width, CC bit layout, icode/condition encodings and reset values.
package cc_cond_unit_pkg;

  localparam int QWORD = 64;

  // CC register layout: {ZF, SF, OF}
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;
  localparam logic [3:0] RNONE    = 4'hF;

  typedef enum logic [3:0] {
    INOP    = 4'h1,
    ICMOVXX = 4'h2,
    IOPQ    = 4'h6,
    IJXX    = 4'h7
  } icodeT;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } condT;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator over the {ZF,SF,OF} flags.
module cond_eval
  import cc_cond_unit_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf;
  logic lessThan;

  assign zf       = cc[ZF];
  assign lessThan = cc[SF] ^ cc[OF];

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lessThan | zf;
      C_L:     cnd = lessThan;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lessThan;
      C_G:     cnd = ~lessThan & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage CC register, condition resolution and E->M pipeline register.
// Optional jXX taken/not-taken counters are built when CC_PERF_EN is defined.
module cc_cond_unit
  import cc_cond_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [2:0]       alu_cc,
  input  logic [QWORD-1:0] e_valE,
  input  logic [QWORD-1:0] e_valA,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             m_stat_bad,
  input  logic             w_stat_bad,
  input  logic             m_stall,
  input  logic             m_bubble,
  output logic             set_cc,
  output logic [2:0]       cc_q,
  output logic             e_cnd,
  output logic [3:0]       e_dstE_eff,
  output logic             M_valid,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [QWORD-1:0] M_valE,
  output logic [QWORD-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic [31:0]      jxx_taken_cnt,
  output logic [31:0]      jxx_nt_cnt
);

  logic rawCnd;
  logic isJxx;
  logic isCmov;
  logic loadM;

  // Conditions always read the registered flags; an OPq one slot ahead has
  // already committed them, so no bypass from alu_cc is required.
  cond_eval uCondEval (
    .cc   (cc_q),
    .ifun (e_ifun),
    .cnd  (rawCnd)
  );

  assign isJxx  = (e_icode == IJXX);
  assign isCmov = (e_icode == ICMOVXX);

  assign e_cnd      = (isJxx | isCmov) & rawCnd;
  assign e_dstE_eff = (isCmov && !e_cnd) ? RNONE : e_dstE;

  assign set_cc = e_valid & (e_icode == IOPQ) & ~m_stat_bad & ~w_stat_bad & ~m_stall;
  assign loadM  = ~m_stall & ~m_bubble & e_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (set_cc) begin
      cc_q <= alu_cc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_valid <= 1'b0;
      M_icode <= INOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (m_stall) begin
      M_valid <= M_valid;
    end else if (!loadM) begin
      M_valid <= 1'b0;
      M_icode <= INOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= e_valA;
      M_dstE  <= e_dstE_eff;
      M_dstM  <= e_dstM;
    end
  end

`ifdef CC_PERF_EN
  logic [31:0] takenCnt;
  logic [31:0] notTakenCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      takenCnt    <= '0;
      notTakenCnt <= '0;
    end else if (loadM && isJxx) begin
      if (e_cnd) begin
        if (takenCnt != '1) takenCnt <= takenCnt + 32'd1;
      end else begin
        if (notTakenCnt != '1) notTakenCnt <= notTakenCnt + 32'd1;
      end
    end
  end

  assign jxx_taken_cnt = takenCnt;
  assign jxx_nt_cnt    = notTakenCnt;
`else
  assign jxx_taken_cnt = '0;
  assign jxx_nt_cnt    = '0;
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed, table-driven bench for cc_cond_unit plus hand-written sequences
// for asynchronous reset and the jXX performance counters.
module tb_cc_cond_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        e_valid = 1'b0;
  logic [3:0]  e_icode = 4'h1;
  logic [3:0]  e_ifun = 4'h0;
  logic [2:0]  alu_cc = 3'b000;
  logic [63:0] e_valE = '0;
  logic [63:0] e_valA = '0;
  logic [3:0]  e_dstE = 4'hF;
  logic [3:0]  e_dstM = 4'hF;
  logic        m_stat_bad = 1'b0;
  logic        w_stat_bad = 1'b0;
  logic        m_stall = 1'b0;
  logic        m_bubble = 1'b0;
  logic        set_cc;
  logic [2:0]  cc_q;
  logic        e_cnd;
  logic [3:0]  e_dstE_eff;
  logic        M_valid;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [31:0] jxx_taken_cnt;
  logic [31:0] jxx_nt_cnt;

  int checks = 0;
  int failures = 0;

  cc_cond_unit dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_cc(alu_cc), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .m_stat_bad(m_stat_bad), .w_stat_bad(w_stat_bad), .m_stall(m_stall), .m_bubble(m_bubble),
    .set_cc(set_cc), .cc_q(cc_q), .e_cnd(e_cnd), .e_dstE_eff(e_dstE_eff),
    .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .jxx_taken_cnt(jxx_taken_cnt), .jxx_nt_cnt(jxx_nt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] ic, fn;
    logic [2:0] alu;
    logic [3:0] de, dm;
    logic       mb, wb, st, bb;
    logic [7:0] tag;
    logic       xs, xc;
    logic [3:0] xde;
    logic [2:0] xcc;
    logic       xmv;
    logic [3:0] xmi;
    logic       xmc;
    logic [3:0] xmde, xmdm;
    logic [7:0] xmtag;
  } vecT;

  vecT vecs[20];

  function automatic vecT mk(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                             input logic [2:0] alu, input logic [3:0] de, input logic [3:0] dm,
                             input logic mb, input logic wb, input logic st, input logic bb,
                             input logic [7:0] tag, input logic xs, input logic xc,
                             input logic [3:0] xde, input logic [2:0] xcc, input logic xmv,
                             input logic [3:0] xmi, input logic xmc, input logic [3:0] xmde,
                             input logic [3:0] xmdm, input logic [7:0] xmtag);
    vecT r;
    r.v = v; r.ic = ic; r.fn = fn; r.alu = alu; r.de = de; r.dm = dm;
    r.mb = mb; r.wb = wb; r.st = st; r.bb = bb; r.tag = tag;
    r.xs = xs; r.xc = xc; r.xde = xde; r.xcc = xcc; r.xmv = xmv; r.xmi = xmi;
    r.xmc = xmc; r.xmde = xmde; r.xmdm = xmdm; r.xmtag = xmtag;
    return r;
  endfunction

  function automatic logic [63:0] valEOf(input logic [7:0] tag);
    return 64'hE000_0000_0000_0000 | {56'h0, tag};
  endfunction

  function automatic logic [63:0] valAOf(input logic [7:0] tag);
    return 64'hA000_0000_0000_0000 | {56'h0, tag};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [2:0] alu, input logic [3:0] de, input logic [3:0] dm,
                       input logic mb, input logic wb, input logic st, input logic bb,
                       input logic [7:0] tag);
    e_valid = v; e_icode = ic; e_ifun = fn; alu_cc = alu; e_dstE = de; e_dstM = dm;
    m_stat_bad = mb; w_stat_bad = wb; m_stall = st; m_bubble = bb;
    e_valE = valEOf(tag); e_valA = valAOf(tag);
  endtask

  task automatic jxx(input logic [3:0] fn, input logic st, input logic bb);
    @(negedge clk);
    drive(1'b1, 4'h7, fn, 3'b000, 4'hF, 4'hF, 1'b0, 1'b0, st, bb, 8'h40);
    @(posedge clk);
  endtask

  initial begin
    // cc is {ZF,SF,OF}; icodes: NOP=1 CMOV=2 OPq=6 JXX=7 MRMOVQ-like=4
    vecs[0]  = mk(1,4'h6,4'h0,3'b010,4'h3,4'hF,0,0,0,0,8'h10, 1,0,4'h3,3'b010, 1,4'h6,0,4'h3,4'hF,8'h10);
    vecs[1]  = mk(1,4'h7,4'h2,3'b000,4'hF,4'hF,0,0,0,0,8'h11, 0,1,4'hF,3'b010, 1,4'h7,1,4'hF,4'hF,8'h11);
    vecs[2]  = mk(1,4'h7,4'h5,3'b000,4'hF,4'hF,0,0,0,0,8'h12, 0,0,4'hF,3'b010, 1,4'h7,0,4'hF,4'hF,8'h12);
    vecs[3]  = mk(1,4'h2,4'h3,3'b000,4'h3,4'hF,0,0,0,0,8'h13, 0,0,4'hF,3'b010, 1,4'h2,0,4'hF,4'hF,8'h13);
    vecs[4]  = mk(1,4'h2,4'h4,3'b000,4'h5,4'hF,0,0,0,0,8'h14, 0,1,4'h5,3'b010, 1,4'h2,1,4'h5,4'hF,8'h14);
    vecs[5]  = mk(1,4'h6,4'h0,3'b100,4'h4,4'hF,1,0,0,0,8'h15, 0,0,4'h4,3'b010, 1,4'h6,0,4'h4,4'hF,8'h15);
    vecs[6]  = mk(1,4'h6,4'h0,3'b001,4'h6,4'hF,0,1,0,0,8'h16, 0,0,4'h6,3'b010, 1,4'h6,0,4'h6,4'hF,8'h16);
    vecs[7]  = mk(1,4'h6,4'h0,3'b100,4'h7,4'hF,0,0,1,1,8'h17, 0,0,4'h7,3'b010, 1,4'h6,0,4'h6,4'hF,8'h16);
    vecs[8]  = mk(1,4'h6,4'h0,3'b100,4'h7,4'hF,0,0,1,1,8'h17, 0,0,4'h7,3'b010, 1,4'h6,0,4'h6,4'hF,8'h16);
    vecs[9]  = mk(1,4'h6,4'h0,3'b100,4'h7,4'hF,0,0,0,1,8'h17, 1,0,4'h7,3'b100, 0,4'h1,0,4'hF,4'hF,8'h00);
    vecs[10] = mk(0,4'h1,4'h0,3'b000,4'h8,4'h9,0,0,0,0,8'h18, 0,0,4'h8,3'b100, 0,4'h1,0,4'hF,4'hF,8'h00);
    vecs[11] = mk(1,4'h7,4'h1,3'b000,4'hF,4'hF,0,0,0,0,8'h19, 0,1,4'hF,3'b100, 1,4'h7,1,4'hF,4'hF,8'h19);
    vecs[12] = mk(1,4'h7,4'h6,3'b000,4'hF,4'hF,0,0,0,0,8'h1A, 0,0,4'hF,3'b100, 1,4'h7,0,4'hF,4'hF,8'h1A);
    vecs[13] = mk(1,4'h7,4'h7,3'b000,4'hF,4'hF,0,0,0,0,8'h1B, 0,0,4'hF,3'b100, 1,4'h7,0,4'hF,4'hF,8'h1B);
    vecs[14] = mk(1,4'h6,4'h0,3'b011,4'h2,4'hF,0,0,0,0,8'h1C, 1,0,4'h2,3'b011, 1,4'h6,0,4'h2,4'hF,8'h1C);
    vecs[15] = mk(1,4'h7,4'h2,3'b000,4'hF,4'hF,0,0,0,0,8'h1D, 0,0,4'hF,3'b011, 1,4'h7,0,4'hF,4'hF,8'h1D);
    vecs[16] = mk(1,4'h7,4'h5,3'b000,4'hF,4'hF,0,0,0,0,8'h1E, 0,1,4'hF,3'b011, 1,4'h7,1,4'hF,4'hF,8'h1E);
    vecs[17] = mk(1,4'h7,4'h6,3'b000,4'hF,4'hF,0,0,0,0,8'h1F, 0,1,4'hF,3'b011, 1,4'h7,1,4'hF,4'hF,8'h1F);
    vecs[18] = mk(1,4'h2,4'h0,3'b000,4'hA,4'hF,0,0,0,0,8'h20, 0,1,4'hA,3'b011, 1,4'h2,1,4'hA,4'hF,8'h20);
    vecs[19] = mk(1,4'h4,4'h0,3'b000,4'hF,4'h7,0,0,0,0,8'h21, 0,0,4'hF,3'b011, 1,4'h4,0,4'hF,4'h7,8'h21);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cc", {61'h0, cc_q}, 64'h4);
    chk("rst_M_valid", {63'h0, M_valid}, 64'h0);
    chk("rst_M_icode", {60'h0, M_icode}, 64'h1);
    chk("rst_M_dstE", {60'h0, M_dstE}, 64'hF);
    chk("rst_M_dstM", {60'h0, M_dstM}, 64'hF);
    chk("rst_M_valE", M_valE, 64'h0);
    chk("rst_set_cc", {63'h0, set_cc}, 64'h0);
    chk("rst_taken", {32'h0, jxx_taken_cnt}, 64'h0);
    chk("rst_nt", {32'h0, jxx_nt_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].ic, vecs[i].fn, vecs[i].alu, vecs[i].de, vecs[i].dm,
            vecs[i].mb, vecs[i].wb, vecs[i].st, vecs[i].bb, vecs[i].tag);
      #1;
      chk($sformatf("v%0d_set_cc", i), {63'h0, set_cc}, {63'h0, vecs[i].xs});
      chk($sformatf("v%0d_e_cnd", i), {63'h0, e_cnd}, {63'h0, vecs[i].xc});
      chk($sformatf("v%0d_dstE_eff", i), {60'h0, e_dstE_eff}, {60'h0, vecs[i].xde});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cc_q", i), {61'h0, cc_q}, {61'h0, vecs[i].xcc});
      chk($sformatf("v%0d_M_valid", i), {63'h0, M_valid}, {63'h0, vecs[i].xmv});
      chk($sformatf("v%0d_M_icode", i), {60'h0, M_icode}, {60'h0, vecs[i].xmi});
      chk($sformatf("v%0d_M_cnd", i), {63'h0, M_cnd}, {63'h0, vecs[i].xmc});
      chk($sformatf("v%0d_M_dstE", i), {60'h0, M_dstE}, {60'h0, vecs[i].xmde});
      chk($sformatf("v%0d_M_dstM", i), {60'h0, M_dstM}, {60'h0, vecs[i].xmdm});
      chk($sformatf("v%0d_M_valE", i), M_valE, vecs[i].xmv ? valEOf(vecs[i].xmtag) : 64'h0);
      chk($sformatf("v%0d_M_valA", i), M_valA, vecs[i].xmv ? valAOf(vecs[i].xmtag) : 64'h0);
    end

    // Asynchronous reset between edges: state must clear without a clock.
    @(negedge clk);
    drive(1'b0, 4'h1, 4'h0, 3'b000, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cc", {61'h0, cc_q}, 64'h4);
    chk("async_M_valid", {63'h0, M_valid}, 64'h0);
    chk("async_M_icode", {60'h0, M_icode}, 64'h1);
    chk("async_M_dstM", {60'h0, M_dstM}, 64'hF);
    @(negedge clk);
    rst = 1'b0;

    // Counter sequence from reset flags ZF=1: E(T) YES(T) NE(N) LE stalled then LE(T) L(N), plus a bubbled jXX.
    jxx(4'h3, 1'b0, 1'b0);
    jxx(4'h0, 1'b0, 1'b0);
    jxx(4'h4, 1'b0, 1'b0);
    jxx(4'h1, 1'b1, 1'b0);
    jxx(4'h1, 1'b0, 1'b0);
    jxx(4'h2, 1'b0, 1'b0);
    jxx(4'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'h1, 4'h0, 3'b000, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
`ifdef CC_PERF_EN
    chk("perf_taken", {32'h0, jxx_taken_cnt}, 64'd3);
    chk("perf_nt", {32'h0, jxx_nt_cnt}, 64'd2);
`else
    chk("perf_taken_off", {32'h0, jxx_taken_cnt}, 64'd0);
    chk("perf_nt_off", {32'h0, jxx_nt_cnt}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_cond_unit.md
# cc_cond_unit

Execute-stage condition-code register, branch/cmov condition evaluator and E→M pipeline register for the Y86-64 pipelined CPU. Sits directly downstream of the 64-bit ALU. It generates the ALU's `set_cc`, latches the ALU's `cc` flags into the architectural CC register, and resolves `Cnd` for jXX/cmovXX. It also registers execute results (`valE`, `valA`, destinations, `Cnd`) into the memory stage under stall/bubble control.

## Interface
Parameters: none; all widths come from `defines.vh` (`QWORD` = 64 bits).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `e_valid`  in  1  E-stage holds a real instruction
- `e_icode`, `e_ifun`  in  4 each  E-stage opcode/function
- `alu_cc`  in  3  flags from ALU (`ZF`/`SF`/`OF` bit indices per `defines.vh`)
- `e_valE`, `e_valA`  in  `QWORD`  ALU result / pass-through operand
- `e_dstE`, `e_dstM`  in  4  destination register IDs
- `m_stat_bad`, `w_stat_bad`  in  1  exception present in M / W stage
- `m_stall`, `m_bubble`  in  1  M-register control
- `set_cc`  out  1  to ALU; update-enable for CC
- `cc_q`  out  3  architectural CC register
- `e_cnd`  out  1  condition result (combinational)
- `e_dstE_eff`  out  4  dstE after cmov suppression (combinational, to forwarding)
- `M_valid`, `M_icode`, `M_cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM`  out  1/4/1/64/64/4/4  M-stage register
- `jxx_taken_cnt`, `jxx_nt_cnt`  out  32 each  perf counters (see Configuration)

## Operation
- `set_cc` = `e_valid` & (`e_icode`==`IOPQ`) & !`m_stat_bad` & !`w_stat_bad` & !`m_stall`.
- CC register: on the clock edge with `set_cc`=1, `cc_q` <= `alu_cc`; otherwise it holds.
- Condition by `e_ifun`:
  - 0 → 1
  - 1 LE → (SF^OF)|ZF
  - 2 L → SF^OF
  - 3 E → ZF
  - 4 NE → !ZF
  - 5 GE → !(SF^OF)
  - 6 G → !(SF^OF)&!ZF
  - 7–15 → 0
- Condition is evaluated from `cc_q` (registered value), never from `alu_cc`.
- `e_cnd` equals the condition for `IJXX` and `ICMOVXX`; it is 0 for all other icodes.
- `e_dstE_eff` = `RNONE` when `e_icode`==`ICMOVXX` & !`e_cnd`; otherwise it equals `e_dstE`.
- M register, per edge, in priority order:
  1. `m_stall`: hold all M outputs (stall wins over bubble).
  2. `m_bubble`, or `e_valid`=0: `M_valid`=0, `M_icode`=`INOP`, `M_cnd`=0, `M_dstE`=`M_dstM`=`RNONE`, `M_valE`/`M_valA`=0.
  3. Else: load `e_*` values, with `e_dstE_eff` → `M_dstE` and `e_cnd` → `M_cnd`.

## Timing
- Reset values (asynchronous):
  - `cc_q` = ZF=1, SF=0, OF=0
  - M register equals the bubble values above
  - counters = 0
- `e_cnd` and `e_dstE_eff` have zero-cycle latency from E inputs and `cc_q`.
- `cc_q` and the M outputs update one edge after their inputs.
- OPq followed immediately by jXX/cmovXX: the dependent instruction, in E one cycle later, sees the updated `cc_q`. No bypass is needed.
- OPq in E while M or W has an exception: CC does not update, and the M register still loads the OPq.
- `m_stall`=1 with OPq in E: no CC update. The OPq updates CC once, on the cycle it finally advances.
- `rst` asserted mid-stream: all state clears immediately, independent of `clk`.

## Configuration
- `CC_PERF_EN` defined:
  - `jxx_taken_cnt` increments when a jXX with `e_cnd`=1 loads into M (not stalled, not bubbled).
  - `jxx_nt_cnt` increments likewise for `e_cnd`=0.
  - Both counters saturate at 32'hFFFF_FFFF and clear on `rst`.
- `CC_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are instantiated.

## Structure
- `defines.vh` (shared) holds:
  - `QWORD`
  - `ZF`/`SF`/`OF` bit indices
  - icode constants `INOP`, `ICMOVXX`, `IOPQ`, `IJXX`
  - condition ifun codes
  - `RNONE`=4'hF
  - the CC reset constant
- One combinational sub-module, `cond_eval`: inputs `cc[2:0]` and `ifun[3:0]`, output `cnd`.
- CC register, M register and counters live in the top module.

## Test plan
- Reset release → `cc_q`=3'b(ZF=1,SF=0,OF=0); `M_icode`=`INOP`; `M_dstE`=`RNONE`; `set_cc`=0.
- OPq with `alu_cc` ZF=0,SF=1,OF=0, then jXX ifun=2 (L) next cycle → `e_cnd`=1; a following jXX ifun=5 (GE) → `e_cnd`=0.
- cmovXX ifun=3 (E) with ZF=0, `e_dstE`=4'h3 → `e_dstE_eff`=`RNONE`; next edge `M_dstE`=`RNONE`, `M_cnd`=0.
- OPq with `m_stat_bad`=1 and `alu_cc` ZF=1,SF=0,OF=0 → `cc_q` unchanged; `M_icode`=`IOPQ` still loads.
- `m_stall`=1 with `m_bubble`=1 for 2 cycles → M outputs hold; `cc_q` holds through an OPq; bubble takes effect once stall drops.
- `CC_PERF_EN`: 3 taken + 2 not-taken jXX, one of them stalled for one cycle → `jxx_taken_cnt`=3, `jxx_nt_cnt`=2.
